// File: rtl/utx_feed.sv
// Word FIFO feeding a UART transmitter: one word in flight, tx_done timeout,
// and a minimum idle gap (in microsecond ticks) between transfers.
module utx_feed #(
  parameter int AW     = 3,
  parameter int GAP_US = 20,
  parameter int TMO_US = 400
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          pluse_us,
  input  logic [15:0]   wr_data,
  input  logic          wr_vld,
  output logic          wr_rdy,
  input  logic          flush,
  input  logic          clr_err,
  output logic [15:0]   tx_data,
  output logic          tx_vld,
  input  logic          tx_done,
  output logic [AW:0]   level,
  output logic          busy,
  output logic          ovf,
  output logic [7:0]    drop_cnt,
  output logic          tmo_err
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [15:0] TMO_LAST = 16'(TMO_US - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_US - 1);
  localparam logic        NO_GAP   = (GAP_US == 0);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} state_t;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;

  state_t        r_state;
  logic [15:0]   r_tmo;
  logic [15:0]   r_gap;
  logic [15:0]   r_tx_data;
  logic          r_tx_vld;
  logic          r_busy;
  logic          r_ovf;
  logic [7:0]    r_drop;
  logic          r_tmo_err;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_rej;
  logic [15:0]   w_head;

  // Full/empty come from the registered count only, so a pop in the same
  // cycle never makes room for a write that arrived while full.
  assign w_full  = (r_cnt == CNT_FULL);
  assign w_empty = (r_cnt == '0);
  assign w_push  = wr_vld & ~w_full & ~flush;
  assign w_rej   = wr_vld &  w_full & ~flush;
  assign w_pop   = (r_state == S_IDLE) & ~w_empty & ~flush;
  assign w_head  = r_mem[r_rptr];

  assign wr_rdy   = ~w_full;
  assign level    = r_cnt;
  assign busy     = r_busy;
  assign tx_data  = r_tx_data;
  assign tx_vld   = r_tx_vld;
  assign ovf      = r_ovf;
  assign drop_cnt = r_drop;
  assign tmo_err  = r_tmo_err;

  always_ff @(posedge clk_sys) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk_sys) begin
    if (rst || flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // A new overflow in the same cycle as clr_err restarts the count at one.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_drop <= 8'd0;
    end else if (w_rej) begin
      r_ovf <= 1'b1;
      if (clr_err)              r_drop <= 8'd1;
      else if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end else if (clr_err) begin
      r_ovf  <= 1'b0;
      r_drop <= 8'd0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx_data <= 16'h0000;
      r_tx_vld  <= 1'b0;
      r_busy    <= 1'b0;
      r_tmo     <= '0;
      r_gap     <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_tx_vld <= 1'b0;
      if (clr_err) r_tmo_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tx_data <= w_head;
            r_state   <= S_SEND;
            r_busy    <= 1'b1;
          end
        end
        S_SEND: begin
          r_tx_vld <= 1'b1;
          r_tmo    <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done || (pluse_us && r_tmo == TMO_LAST)) begin
            if (!tx_done) r_tmo_err <= 1'b1;
            r_gap <= '0;
            if (NO_GAP) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_GAP;
            end
          end else if (pluse_us) begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_GAP: begin
          if (pluse_us) begin
            if (r_gap == GAP_LAST) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_utx_feed.sv
// Scoreboard bench for utx_feed: expected words queued at write time, a
// monitor pops and compares on every tx_vld pulse.
module tb_utx_feed;
  localparam int AW     = 3;
  localparam int GAP_US = 20;
  localparam int TMO_US = 400;
  localparam int PDIV   = 5;

  logic          clk_sys = 1'b0;
  logic          rst = 1'b1;
  logic          pluse_us = 1'b0;
  logic [15:0]   wr_data = 16'h0;
  logic          wr_vld = 1'b0;
  logic          wr_rdy;
  logic          flush = 1'b0;
  logic          clr_err = 1'b0;
  logic [15:0]   tx_data;
  logic          tx_vld;
  logic          tx_done = 1'b0;
  logic [AW:0]   level;
  logic          busy;
  logic          ovf;
  logic [7:0]    drop_cnt;
  logic          tmo_err;

  utx_feed #(.AW(AW), .GAP_US(GAP_US), .TMO_US(TMO_US)) dut (
    .clk_sys(clk_sys), .rst(rst), .pluse_us(pluse_us),
    .wr_data(wr_data), .wr_vld(wr_vld), .wr_rdy(wr_rdy),
    .flush(flush), .clr_err(clr_err),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_done(tx_done),
    .level(level), .busy(busy), .ovf(ovf), .drop_cnt(drop_cnt), .tmo_err(tmo_err)
  );

  always #5 clk_sys = ~clk_sys;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  int          vld_seen = 0;
  int          us_done = 0;
  int          us_vld = 0;
  bit          done_flag = 1'b0;
  int          pcnt = 0;
  int          tgt = 0;

  initial forever begin
    @(negedge clk_sys);
    pcnt++;
    pluse_us = ((pcnt % PDIV) == 0);
  end

  // Microsecond bookkeeping as seen by the DUT at each rising edge.
  always @(posedge clk_sys) begin
    if (rst) begin
      done_flag <= 1'b0;
      us_done   <= 0;
    end else if (tx_done) begin
      done_flag <= 1'b1;
      us_done   <= 0;
    end else begin
      if (tx_vld) done_flag <= 1'b0;
      if (pluse_us) us_done <= us_done + 1;
    end
    if (tx_vld) us_vld <= pluse_us ? 1 : 0;
    else if (pluse_us) us_vld <= us_vld + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_sys);
    #1;
    if (tx_vld === 1'b1) begin
      vld_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx_vld: got tx_vld with data %h, expected none", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("tx_data_order", {16'h0, tx_data}, {16'h0, mon_exp});
      end
      chk("busy_at_tx_vld", {31'h0, busy}, 32'h1);
      if (done_flag) begin
        checks++;
        if (us_done < GAP_US) begin
          errors++;
          $display("FAIL gap_after_done: got %0d us expected >= %0d", us_done, GAP_US);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic wr(input logic [15:0] d, input bit acc);
    wr_data = d;
    wr_vld  = 1'b1;
    if (acc) exp_q.push_back(d);
    tick();
    wr_vld = 1'b0;
  endtask

  task automatic send_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic wait_vld(input int target, input string nm);
    int n = 0;
    while (vld_seen < target && n < 3000) begin
      tick();
      n++;
    end
    chk(nm, {31'h0, vld_seen >= target}, 32'h1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      tick();
      n++;
    end
    chk(nm, {31'h0, busy}, 32'h0);
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_tx_vld"},   {31'h0, tx_vld},   32'h0);
    chk({pfx, "_tx_data"},  {16'h0, tx_data},  32'h0);
    chk({pfx, "_wr_rdy"},   {31'h0, wr_rdy},   32'h1);
    chk({pfx, "_level"},    {28'h0, level},    32'h0);
    chk({pfx, "_busy"},     {31'h0, busy},     32'h0);
    chk({pfx, "_ovf"},      {31'h0, ovf},      32'h0);
    chk({pfx, "_drop_cnt"}, {24'h0, drop_cnt}, 32'h0);
    chk({pfx, "_tmo_err"},  {31'h0, tmo_err},  32'h0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    tick();
    tick();
    chk_reset("rst0");
    rst = 1'b0;
    tick();

    // Single word: latency, busy, and gap length after tx_done
    wr(16'hA55A, 1'b1);
    chk("lat_e0_tx_vld", {31'h0, tx_vld}, 32'h0);
    tick();
    chk("lat_e1_tx_vld", {31'h0, tx_vld}, 32'h0);
    chk("lat_e1_busy", {31'h0, busy}, 32'h1);
    tick();
    chk("lat_e2_tx_vld", {31'h0, tx_vld}, 32'h1);
    chk("lat_e2_tx_data", {16'h0, tx_data}, 32'hA55A);
    send_done();
    wait_idle("single_idle");
    chk("single_gap_us", us_done, GAP_US);
    chk("single_level", {28'h0, level}, 32'h0);
    tgt = vld_seen;
    chk("single_vld_count", tgt, 1);

    // Three back-to-back words, tx_done 300 us after each tx_vld
    wr(16'h1111, 1'b1);
    wr(16'h2222, 1'b1);
    wr(16'h3333, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tgt++;
      wait_vld(tgt, "burst3_vld");
      repeat (300 * PDIV) tick();
      send_done();
    end
    wait_idle("burst3_idle");

    // Fill to full with tx_done withheld, then overflow and clear paths
    for (int i = 0; i < 8; i++) wr(16'h8000 + 16'(i), 1'b1);
    tgt++;
    wait_vld(tgt, "fill_first_vld");
    chk("fill_level7", {28'h0, level}, 32'h7);
    chk("fill_rdy_at7", {31'h0, wr_rdy}, 32'h1);
    wr(16'h8008, 1'b1);
    chk("fill_level8", {28'h0, level}, 32'h8);
    chk("fill_rdy_at8", {31'h0, wr_rdy}, 32'h0);
    chk("fill_ovf_before", {31'h0, ovf}, 32'h0);
    wr(16'hDEAD, 1'b0);
    wr(16'hBEEF, 1'b0);
    chk("ovf_set", {31'h0, ovf}, 32'h1);
    chk("drop_cnt_2", {24'h0, drop_cnt}, 32'h2);
    chk("ovf_level_kept", {28'h0, level}, 32'h8);
    wr_data = 16'hBAD0;
    wr_vld  = 1'b1;
    clr_err = 1'b1;
    tick();
    wr_vld  = 1'b0;
    clr_err = 1'b0;
    chk("clr_set_wins_ovf", {31'h0, ovf}, 32'h1);
    chk("clr_set_wins_drop", {24'h0, drop_cnt}, 32'h1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_ovf", {31'h0, ovf}, 32'h0);
    chk("clr_drop", {24'h0, drop_cnt}, 32'h0);

    // First word never acknowledged: timeout after TMO_US ticks
    n = 0;
    while (tmo_err !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    chk("tmo_err_set", {31'h0, tmo_err}, 32'h1);
    chk("tmo_us", us_vld, TMO_US);
    chk("tmo_busy_gap", {31'h0, busy}, 32'h1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("tmo_err_clr", {31'h0, tmo_err}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tgt++;
      wait_vld(tgt, "drain_vld");
      tick();
      send_done();
    end
    wait_idle("drain_idle");
    chk("drain_level", {28'h0, level}, 32'h0);

    // Flush during WAIT with five words queued, write in the flush cycle
    for (int i = 0; i < 6; i++) wr(16'h5000 + 16'(i), 1'b1);
    tgt++;
    wait_vld(tgt, "flush_vld");
    chk("flush_level5", {28'h0, level}, 32'h5);
    wr_data = 16'hF00D;
    wr_vld  = 1'b1;
    flush   = 1'b1;
    tick();
    wr_vld  = 1'b0;
    flush   = 1'b0;
    exp_q.delete();
    chk("flush_level0", {28'h0, level}, 32'h0);
    chk("flush_tx_data", {16'h0, tx_data}, 32'h5000);
    chk("flush_no_ovf", {31'h0, ovf}, 32'h0);
    chk("flush_busy", {31'h0, busy}, 32'h1);
    send_done();
    wait_idle("flush_idle");
    repeat (40) tick();
    chk("flush_no_more_vld", vld_seen, tgt);

    // Reset mid-transfer with three words queued
    for (int i = 0; i < 4; i++) wr(16'h4200 + 16'(i), 1'b1);
    tgt++;
    wait_vld(tgt, "rst_mid_vld");
    chk("rst_mid_level3", {28'h0, level}, 32'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk_reset("rst_mid");
    send_done();
    repeat (150) tick();
    chk("rst_stray_done_no_vld", vld_seen, tgt);
    chk("rst_stray_done_busy", {31'h0, busy}, 32'h0);
    wr(16'h7777, 1'b1);
    tgt++;
    wait_vld(tgt, "post_rst_vld");
    tick();
    send_done();
    wait_idle("post_rst_idle");
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
